// File: rtl/seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - state_e  : 3-bit control state encoding used by the top-level FSM
//   - MAX_W    : widest operand the magnitude helper can handle (WIDTH < MAX_W)
//   - abs_mag  : unsigned magnitude of a sign-extended operand
// No ports (package).
// ---------------------------------------------------------------------------
package seq_multiplier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVAL  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_SIGN  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int MAX_W = 64;

  // The caller sign-extends the operand to MAX_W bits when it is signed, so
  // the MSB here is the true sign. Negating the extended value means the
  // most negative WIDTH-bit operand yields +2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits after the caller truncates.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input logic             signed_mode);
    logic [MAX_W-1:0] mag;
    mag = value;
    if (signed_mode && value[MAX_W-1]) begin
      mag = (~value) + MAX_W'(1);
    end
    return mag;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Start/done handshake bundle between a sequencer and the multiplier.
//   start       : request, sampled only while the multiplier is idle
//   signed_mode : 1 = operands are two's complement (sampled with start)
//   a_in, b_in  : multiplicand / multiplier (sampled with start)
//   busy        : operation in progress
//   done        : result valid, held until start is low
//   product     : 2*WIDTH-bit result register
// Modports: master = sequencer side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output busy, done, product
  );

endinterface

// File: rtl/seq_multiplier_dp.sv
// ---------------------------------------------------------------------------
// seq_multiplier_dp
// Datapath of the shift-add multiplier: accumulator {C,A}, multiplier/low
// product Q, multiplicand magnitude B, bit counter, result sign and the
// product register.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ld_i              : capture operand magnitudes and clear accumulator
//   add_en_i          : {C,A} = A + B
//   sh_en_i           : {C,A,Q} >>= 1, count -= 1
//   sign_en_i         : product = neg ? -{A,Q} : {A,Q}
//   zero_ld_i         : product = 0 (zero-operand early exit)
//   signed_mode_i     : operand interpretation for the capture
//   a_i, b_i          : raw operands
//   qlsb_o            : current multiplier bit Q[0]
//   cnt_zero_o        : the shift in progress consumes the final bit
//   op_zero_o         : either raw operand is zero
//   product_o         : product register
// ---------------------------------------------------------------------------
module seq_multiplier_dp
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_i,
  input  logic               add_en_i,
  input  logic               sh_en_i,
  input  logic               sign_en_i,
  input  logic               zero_ld_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               qlsb_o,
  output logic               cnt_zero_o,
  output logic               op_zero_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   a_q;
  logic               c_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   count_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;

  // Operand magnitudes: sign-extend only in signed mode so abs_mag sees the
  // real sign, then keep the low WIDTH bits (the magnitude always fits).
  always_comb begin
    absA = WIDTH'(abs_mag({{(MAX_W-WIDTH){a_i[WIDTH-1] & signed_mode_i}}, a_i}, signed_mode_i));
    absB = WIDTH'(abs_mag({{(MAX_W-WIDTH){b_i[WIDTH-1] & signed_mode_i}}, b_i}, signed_mode_i));
  end

  assign qlsb_o     = q_q[0];
  assign cnt_zero_o = (count_q == CNT_W'(1));
  assign op_zero_o  = (a_i == '0) || (b_i == '0);
  assign product_o  = product_q;

  // Working registers. Capture, add and shift are mutually exclusive because
  // the FSM only ever raises one of them per cycle; the product register is
  // written independently so the zero exit can clear it during the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      c_q       <= 1'b0;
      q_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (ld_i) begin
        a_q     <= '0;
        c_q     <= 1'b0;
        b_q     <= absA;
        q_q     <= absB;
        count_q <= CNT_W'(WIDTH);
        neg_q   <= signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      end else if (add_en_i) begin
        {c_q, a_q} <= {1'b0, a_q} + {1'b0, b_q};
      end else if (sh_en_i) begin
        {c_q, a_q, q_q} <= {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
        count_q         <= count_q - CNT_W'(1);
      end

      if (zero_ld_i) begin
        product_q <= '0;
      end else if (sign_en_i) begin
        product_q <= neg_q ? -{a_q, q_q} : {a_q, q_q};
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle shift-add multiplier (unsigned or two's complement per
// operation) with a level start/done handshake and a zero-operand early exit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation
//   bus   : seq_multiplier_if slave modport (start, signed_mode, a_in, b_in,
//           busy, done, product)
// ---------------------------------------------------------------------------
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus
);

  state_e state_q;
  logic   busy_q;
  logic   done_q;

  logic   ld;
  logic   zeroLd;
  logic   addEn;
  logic   shEn;
  logic   signEn;
  logic   qlsb;
  logic   cntZero;
  logic   opZero;

  // Datapath strobes decoded from the current state. A capture happens only
  // from IDLE, which is what makes start pulses during an operation harmless.
  always_comb begin
    ld     = (state_q == ST_IDLE) && bus.start;
    zeroLd = ld && opZero;
    addEn  = (state_q == ST_ADD);
    shEn   = (state_q == ST_SHIFT);
    signEn = (state_q == ST_SIGN);
  end

  seq_multiplier_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_i          (ld),
    .add_en_i      (addEn),
    .sh_en_i       (shEn),
    .sign_en_i     (signEn),
    .zero_ld_i     (zeroLd),
    .signed_mode_i (bus.signed_mode),
    .a_i           (bus.a_in),
    .b_i           (bus.b_in),
    .qlsb_o        (qlsb),
    .cnt_zero_o    (cntZero),
    .op_zero_o     (opZero),
    .product_o     (bus.product)
  );

  // Control FSM with registered busy/done. busy is set on entry to EVAL and
  // cleared on entry to DONE, so the two flags can never overlap. DONE waits
  // for start to drop so a held request cannot start a second operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (opZero) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_EVAL;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          state_q <= qlsb ? ST_ADD : ST_SHIFT;
        end
        ST_ADD: begin
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          state_q <= cntZero ? ST_SIGN : ST_EVAL;
        end
        ST_SIGN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          if (!bus.start) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Directed self-checking bench for seq_multiplier at WIDTH=8: products and
// busy-cycle counts against hand-computed values, handshake corner cases,
// asynchronous abort, plus a short run of random operands against a
// behavioural multiply.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  seq_multiplier_if #(.WIDTH(8)) mulIf ();

  seq_multiplier #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mulIf)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Last-resort guard in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation: start for one cycle, scramble the operands after the
  // capture, count busy cycles until done, then check product, latency and
  // the done release. With glitch set, a second request with different
  // operands is pulsed while the unit is busy.
  task automatic applyStimulus(input string tag, input logic sm,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expProd, input int expBusy,
                               input bit glitch);
    int  busyCnt;
    bit  gotDone;
    bit  overlap;
    busyCnt = 0;
    gotDone = 1'b0;
    overlap = 1'b0;
    @(negedge clk);
    mulIf.signed_mode = sm;
    mulIf.a_in        = a;
    mulIf.b_in        = b;
    mulIf.start       = 1'b1;
    @(posedge clk);
    #1;
    mulIf.start       = 1'b0;
    mulIf.a_in        = ~a;
    mulIf.b_in        = 8'h5A;
    mulIf.signed_mode = ~sm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mulIf.busy && mulIf.done) overlap = 1'b1;
      if (mulIf.done) begin
        gotDone = 1'b1;
        break;
      end
      if (mulIf.busy) busyCnt++;
      if (glitch && busyCnt == 5) begin
        mulIf.a_in  = 8'd2;
        mulIf.b_in  = 8'd2;
        mulIf.start = 1'b1;
      end else begin
        mulIf.start = 1'b0;
      end
    end
    checkOutput({tag, " done seen"}, 32'(gotDone), 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({tag, " product"}, 32'(mulIf.product), 32'(expProd));
    checkOutput({tag, " busy&done"}, 32'(overlap), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done released"}, 32'(mulIf.done), 32'd0);
  endtask

  // Main sequence.
  initial begin
    logic [7:0]         ra;
    logic [7:0]         rb;
    logic               rsm;
    logic [7:0]         magB;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic [15:0]        rp;
    int                 rbusy;
    int                 waitCnt;

    testsRun          = 0;
    testsFailed       = 0;
    rst_n             = 1'b0;
    mulIf.start       = 1'b0;
    mulIf.signed_mode = 1'b0;
    mulIf.a_in        = '0;
    mulIf.b_in        = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(mulIf.busy), 32'd0);
    checkOutput("reset done", 32'(mulIf.done), 32'd0);
    checkOutput("reset product", 32'(mulIf.product), 32'd0);
    rst_n = 1'b1;

    // Directed vectors: busy cycles = 16 + popcount(|b|) + 1, or 0 on zero exit.
    applyStimulus("u13x11",    1'b0, 8'd13,  8'd11,  16'h008F, 20, 1'b0);
    applyStimulus("s-7x5",     1'b1, 8'hF9,  8'h05,  16'hFFDD, 19, 1'b0);
    applyStimulus("s-128x-128",1'b1, 8'h80,  8'h80,  16'h4000, 18, 1'b0);
    applyStimulus("u255x255",  1'b0, 8'hFF,  8'hFF,  16'hFE01, 25, 1'b0);
    applyStimulus("s-1x-1",    1'b1, 8'hFF,  8'hFF,  16'h0001, 18, 1'b0);
    applyStimulus("u0x200",    1'b0, 8'd0,   8'd200, 16'h0000, 0,  1'b0);
    applyStimulus("u77x0",     1'b0, 8'd77,  8'd0,   16'h0000, 0,  1'b0);
    applyStimulus("s0x-128",   1'b1, 8'h00,  8'h80,  16'h0000, 0,  1'b0);
    applyStimulus("s127x-128", 1'b1, 8'h7F,  8'h80,  16'hC080, 18, 1'b0);
    applyStimulus("s-3x-5",    1'b1, 8'hFD,  8'hFB,  16'h000F, 19, 1'b0);
    applyStimulus("s-128x1",   1'b1, 8'h80,  8'h01,  16'hFF80, 18, 1'b0);
    applyStimulus("s5x6",      1'b1, 8'h05,  8'h06,  16'h001E, 19, 1'b0);
    applyStimulus("u200x3",    1'b0, 8'hC8,  8'h03,  16'h0258, 19, 1'b0);
    applyStimulus("u100x128",  1'b0, 8'h64,  8'h80,  16'h3200, 18, 1'b0);
    applyStimulus("glitch",    1'b0, 8'd13,  8'd11,  16'h008F, 20, 1'b1);

    // start held high from request through DONE: done must hold, no re-trigger.
    @(negedge clk);
    mulIf.signed_mode = 1'b0;
    mulIf.a_in        = 8'd13;
    mulIf.b_in        = 8'd11;
    mulIf.start       = 1'b1;
    waitCnt = 0;
    while (!mulIf.done && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("hold done seen", 32'(mulIf.done), 32'd1);
    checkOutput("hold product", 32'(mulIf.product), 32'h008F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold done %0d", i), 32'(mulIf.done), 32'd1);
      checkOutput($sformatf("hold busy %0d", i), 32'(mulIf.busy), 32'd0);
    end
    mulIf.start = 1'b0;
    @(negedge clk);
    checkOutput("hold release done", 32'(mulIf.done), 32'd0);
    @(negedge clk);
    checkOutput("hold no retrigger", 32'(mulIf.busy), 32'd0);

    // Asynchronous reset in the middle of an operation.
    mulIf.a_in  = 8'd13;
    mulIf.b_in  = 8'd11;
    mulIf.start = 1'b1;
    @(posedge clk);
    #1;
    mulIf.start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort busy before", 32'(mulIf.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(mulIf.busy), 32'd0);
    checkOutput("abort done", 32'(mulIf.done), 32'd0);
    checkOutput("abort product", 32'(mulIf.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post-reset 3x3", 1'b0, 8'd3, 8'd3, 16'h0009, 19, 1'b0);

    // Random operands against a behavioural multiply.
    for (int i = 0; i < 60; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsm = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra = 8'd0;
      if (rsm) begin
        sa = {{8{ra[7]}}, ra};
        sb = {{8{rb[7]}}, rb};
        rp = 16'(sa * sb);
      end else begin
        rp = 16'({8'd0, ra} * {8'd0, rb});
      end
      magB = rb;
      if (rsm && rb[7]) magB = ~rb + 8'd1;
      if (ra == 8'd0 || rb == 8'd0) rbusy = 0;
      else rbusy = 17 + $countones(magB);
      applyStimulus($sformatf("rnd%0d", i), rsm, ra, rb, rp, rbusy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
